// File: rtl/neuron_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the neuron MAC slice.
package neuron_pkg;

  localparam int PIXEL_W    = 8;
  localparam int WEIGHT_W   = 5;
  localparam int LANES      = 4;
  localparam int NUM_PIXELS = 12288;
  localparam int ACC_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unsigned pixel gains a zero sign bit, so the signed product needs pw+ww+1 bits.
  function automatic int prod_width(input int pw, input int ww);
    return pw + ww + 1;
  endfunction

endpackage

// File: rtl/neuron_lane.sv
// One combinational lane: unsigned pixel times signed weight, signed product out.
module neuron_lane
  import neuron_pkg::*;
#(
  parameter int PixelWidth  = PIXEL_W,
  parameter int WeightWidth = WEIGHT_W,
  localparam int ProdW      = prod_width(PixelWidth, WeightWidth)
) (
  input  logic [PixelWidth-1:0]  pixel,
  input  logic [WeightWidth-1:0] weight,
  output logic [ProdW-1:0]       product
);

  logic signed [ProdW-1:0] px_ext;
  logic signed [ProdW-1:0] wt_ext;

  assign px_ext  = {{(ProdW-PixelWidth){1'b0}}, pixel};
  assign wt_ext  = {{(ProdW-WeightWidth){weight[WeightWidth-1]}}, weight};
  assign product = px_ext * wt_ext;

endmodule

// File: rtl/neuron_mac.sv
// Multi-lane streaming dot product with bias and cat decision.
// Optional NEURON_MAC_SATURATE_EN: saturating accumulator plus sticky sat_flag.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int PixelWidth  = PIXEL_W,
  parameter int WeightWidth = WEIGHT_W,
  parameter int Lanes       = LANES,
  parameter int NumPixels   = NUM_PIXELS,
  parameter int AccWidth    = ACC_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [Lanes*PixelWidth-1:0]  pixels,
  input  logic [Lanes*WeightWidth-1:0] weights,
  input  logic [WeightWidth-1:0]       bias,
  output logic                         busy,
  output logic                         out_valid,
  output logic [AccWidth-1:0]          result,
`ifdef NEURON_MAC_SATURATE_EN
  output logic                         sat_flag,
`endif
  output logic                         is_cat
);

  localparam int ProdW    = prod_width(PixelWidth, WeightWidth);
  localparam int Beats    = NumPixels / Lanes;
  localparam int CntW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int LaneBits = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int SumW     = ((AccWidth > ProdW + LaneBits) ? AccWidth : ProdW + LaneBits) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  state_t                   state, state_nxt;
  logic [CntW-1:0]          beat_cnt;
  logic                     drain_cnt;
  logic                     accept;
  logic [Lanes*ProdW-1:0]   prod_comb;
  logic [Lanes*ProdW-1:0]   prod_q;
  logic                     v1;
  logic [AccWidth-1:0]      acc;
  logic [AccWidth-1:0]      acc_nxt;
  logic [SumW-1:0]          sum_wide;
`ifdef NEURON_MAC_SATURATE_EN
  logic                     sat_hit;
`endif

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    neuron_lane #(
      .PixelWidth (PixelWidth),
      .WeightWidth(WeightWidth)
    ) u_lane (
      .pixel  (pixels[i*PixelWidth +: PixelWidth]),
      .weight (weights[i*WeightWidth +: WeightWidth]),
      .product(prod_comb[i*ProdW +: ProdW])
    );
  end

  assign accept = in_valid && in_ready;

  // Tree sum and accumulate are computed wide so both wrap and clamp see the true total.
  always_comb begin
    sum_wide = {{(SumW-AccWidth){acc[AccWidth-1]}}, acc};
    for (int unsigned i = 0; i < Lanes; i++) begin
      sum_wide = sum_wide + {{(SumW-ProdW){prod_q[i*ProdW+ProdW-1]}}, prod_q[i*ProdW +: ProdW]};
    end
`ifdef NEURON_MAC_SATURATE_EN
    sat_hit = !((&sum_wide[SumW-1:AccWidth-1]) || !(|sum_wide[SumW-1:AccWidth-1]));
    if (sat_hit) begin
      acc_nxt = sum_wide[SumW-1] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}};
    end else begin
      acc_nxt = sum_wide[AccWidth-1:0];
    end
`else
    acc_nxt = sum_wide[AccWidth-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (accept && beat_cnt == LastBeat) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
      v1        <= 1'b0;
      prod_q    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      is_cat    <= 1'b0;
`ifdef NEURON_MAC_SATURATE_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      v1        <= accept;
      if (accept) begin
        prod_q   <= prod_comb;
        beat_cnt <= (beat_cnt == LastBeat) ? '0 : beat_cnt + CntW'(1);
      end
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

      if (state == IDLE && start) begin
        acc      <= {{(AccWidth-WeightWidth){bias[WeightWidth-1]}}, bias};
        beat_cnt <= '0;
        result   <= '0;
        is_cat   <= 1'b0;
`ifdef NEURON_MAC_SATURATE_EN
        sat_flag <= 1'b0;
`endif
      end else if (v1) begin
        acc <= acc_nxt;
`ifdef NEURON_MAC_SATURATE_EN
        if (sat_hit) sat_flag <= 1'b1;
`endif
      end

      if (state == DONE) begin
        out_valid <= 1'b1;
        result    <= acc;
        is_cat    <= !acc[AccWidth-1] && (|acc);
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with NumPixels=8, Lanes=4; a 12-bit accumulator copy exercises overflow.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] pixels = '0;
  logic [19:0] weights = '0;
  logic [4:0]  bias = '0;

  logic        in_ready, busy, out_valid, is_cat;
  logic [31:0] result;
  logic        in_ready12, busy12, out_valid12, is_cat12;
  logic [11:0] result12;
`ifdef NEURON_MAC_SATURATE_EN
  logic        sat_flag, sat_flag12;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac #(
    .PixelWidth(8), .WeightWidth(5), .Lanes(4), .NumPixels(8), .AccWidth(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .pixels(pixels), .weights(weights), .bias(bias), .busy(busy),
    .out_valid(out_valid), .result(result),
`ifdef NEURON_MAC_SATURATE_EN
    .sat_flag(sat_flag),
`endif
    .is_cat(is_cat)
  );

  neuron_mac #(
    .PixelWidth(8), .WeightWidth(5), .Lanes(4), .NumPixels(8), .AccWidth(12)
  ) dut12 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready12),
    .pixels(pixels), .weights(weights), .bias(bias), .busy(busy12),
    .out_valid(out_valid12), .result(result12),
`ifdef NEURON_MAC_SATURATE_EN
    .sat_flag(sat_flag12),
`endif
    .is_cat(is_cat12)
  );

  localparam logic [31:0] P1   = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] P2   = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [31:0] PFF  = 32'hFFFF_FFFF;
  localparam logic [31:0] P0   = 32'h0;
  localparam logic [19:0] W1   = {4{5'd1}};
  localparam logic [19:0] WM16 = {4{5'b10000}};
  localparam logic [19:0] W15  = {4{5'd15}};

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] b);
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] p, input logic [19:0] w);
    pixels   = p;
    weights  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("done_timeout", out_valid, 1);
  endtask

  int n;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", $signed(result), 0);
    chk("rst_is_cat", is_cat, 0);
    rst = 1'b0;
    tick();

    // Basic image: weights 1, exact latency checked cycle by cycle
    do_start(5'd0);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    beat(P1, W1);
    chk("t1_mid_ready", in_ready, 1);
    beat(P2, W1);
    chk("t1_drain_ready", in_ready, 0);
    tick();
    chk("t1_lat1", out_valid, 0);
    tick();
    chk("t1_lat2", out_valid, 0);
    tick();
    chk("t1_lat3", out_valid, 1);
    chk("t1_result", $signed(result), 36);
    chk("t1_is_cat", is_cat, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_result12", $signed(result12), 36);
    tick();
    chk("t1_pulse", out_valid, 0);
    chk("t1_hold", $signed(result), 36);

    // Most negative weight, full-scale pixels, negative bias
    do_start(5'b10000);
    chk("t2_cleared", $signed(result), 0);
    beat(PFF, WM16);
    beat(PFF, WM16);
    wait_done(n);
    chk("t2_result", $signed(result), -32656);
    chk("t2_is_cat", is_cat, 0);

    // Stall bubbles between beats
    do_start(5'd0);
    beat(P1, W1);
    tick();
    chk("t3_stall_ready", in_ready, 1);
    tick();
    chk("t3_stall_busy", busy, 1);
    beat(P2, W1);
    wait_done(n);
    chk("t3_latency", n, 3);
    chk("t3_result", $signed(result), 36);

    // Reset mid-image, then fresh image with zero pixels
    do_start(5'd5);
    beat(P1, W1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ready", in_ready, 0);
    chk("t4_rst_result", $signed(result), 0);
    tick();
    do_start(5'd3);
    beat(P0, W1);
    beat(P0, W1);
    wait_done(n);
    chk("t4_result", $signed(result), 3);
    chk("t4_is_cat", is_cat, 1);

    // start while busy is ignored
    do_start(5'd0);
    beat(P1, W1);
    do_start(5'd7);
    beat(P2, W1);
    chk("t5_count_kept", in_ready, 0);
    wait_done(n);
    chk("t5_result", $signed(result), 36);
    tick();

    // start with in_valid in IDLE: beat not taken
    pixels   = P1;
    weights  = W1;
    in_valid = 1'b1;
    bias     = 5'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("t5_idle_busy", busy, 1);
    chk("t5_idle_clear", $signed(result), 0);
    beat(P1, W1);
    chk("t5_idle_not_counted", in_ready, 1);
    beat(P2, W1);
    wait_done(n);
    chk("t5_idle_result", $signed(result), 36);
    tick();

    // start coinciding with DONE is ignored
    do_start(5'd0);
    beat(P1, W1);
    beat(P2, W1);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_done_valid", out_valid, 1);
    chk("t6_done_result", $signed(result), 36);
    tick();
    chk("t6_not_started", busy, 0);
    chk("t6_held", $signed(result), 36);

    // Overflow of the narrow accumulator
    do_start(5'd0);
`ifdef NEURON_MAC_SATURATE_EN
    chk("t7_sat_clear", sat_flag12, 0);
`endif
    beat(PFF, W15);
    beat(PFF, W15);
    wait_done(n);
    chk("t7_result32", $signed(result), 30600);
    chk("t7_is_cat32", is_cat, 1);
    chk("t7_valid12", out_valid12, 1);
`ifdef NEURON_MAC_SATURATE_EN
    chk("t7_result12_sat", $signed(result12), 2047);
    chk("t7_sat_flag12", sat_flag12, 1);
    chk("t7_sat_flag32", sat_flag, 0);
`else
    chk("t7_result12_wrap", $signed(result12), 1928);
`endif
    chk("t7_is_cat12", is_cat12, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
